// File: rtl/fixed3_reflect_pkg.sv
// Shared fixed-point definitions for the vector pipeline.
//   Fixed     : signed Q16.16 scalar
//   Fixed3    : packed vector of three Fixed, index 0 = x, 1 = y, 2 = z
//   sat_fixed : clamps a wide signed value into the Fixed range
package fixed3_reflect_pkg;

  localparam int FIXED_WIDTH = 32;
  localparam int FRAC_BITS   = 16;
  localparam int ACC_WIDTH   = FIXED_WIDTH + 3;
  localparam int PROD_WIDTH  = FIXED_WIDTH + ACC_WIDTH - FRAC_BITS;
  localparam int WIDE_WIDTH  = 64;

  typedef logic signed [FIXED_WIDTH-1:0] Fixed;
  typedef Fixed [2:0] Fixed3;

  localparam Fixed FIXED_ONE = 32'sh0001_0000;

  localparam logic signed [WIDE_WIDTH-1:0] FIXED_MAX_W = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [WIDE_WIDTH-1:0] FIXED_MIN_W = 64'shFFFF_FFFF_8000_0000;

  function automatic Fixed sat_fixed(input logic signed [WIDE_WIDTH-1:0] v);
    Fixed res;
    if (v > FIXED_MAX_W)      res = 32'sh7FFF_FFFF;
    else if (v < FIXED_MIN_W) res = 32'sh8000_0000;
    else                      res = v[FIXED_WIDTH-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fixed3_reflect_mul.sv
// fixed_mul_shift: combinational signed multiply followed by an arithmetic
// right shift of FRAC_BITS (floor).
//   a : Fixed operand
//   b : ACC_WIDTH-bit signed operand
//   p : (a*b)>>>FRAC_BITS, full PROD_WIDTH precision
module fixed_mul_shift
  import fixed3_reflect_pkg::*;
(
  input  Fixed                         a,
  input  logic signed [ACC_WIDTH-1:0]  b,
  output logic signed [PROD_WIDTH-1:0] p
);

  localparam int FULL_WIDTH = FIXED_WIDTH + ACC_WIDTH;

  logic signed [FULL_WIDTH-1:0] prod;

  always_comb begin
    prod = FULL_WIDTH'(a) * FULL_WIDTH'(b);
    p    = PROD_WIDTH'(prod >>> FRAC_BITS);
  end

endmodule

// File: rtl/fixed3_reflect.sv
// fixed3_reflect: reflects direction d about unit normal n,
// r = d - 2(d.n)n, using one shared multiplier over seven cycles.
//   clk, reset : clock and synchronous active-high reset
//   strobe     : start request, taken only when idle
//   d, n       : incident direction and surface normal (Fixed3)
//   busy       : operation in progress
//   valid      : one-cycle pulse when r and dot are updated
//   r, dot     : reflected vector and d.n (saturated)
module fixed3_reflect
  import fixed3_reflect_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  strobe,
  input  Fixed3 d,
  input  Fixed3 n,
  output logic  busy,
  output logic  valid,
  output Fixed3 r,
  output Fixed  dot
);

  localparam int DIFF_WIDTH = PROD_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, DOT0, DOT1, DOT2, SC0, SC1, SC2
  } state_t;

  state_t                      state_q, state_d;
  Fixed3                       d_q, d_d, n_q, n_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, k_q, k_d;
  Fixed                        dot_pend_q, dot_pend_d;
  Fixed3                       r_pend_q, r_pend_d;
  Fixed3                       r_q, r_d;
  Fixed                        dot_q, dot_d;
  logic                        valid_q, valid_d;

  logic [1:0]                   idx;
  logic                         is_dot;
  Fixed                         mul_a;
  logic signed [ACC_WIDTH-1:0]  mul_b;
  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [DIFF_WIDTH-1:0] diff;
  Fixed                         r_i;

  // Component select and multiplier operand steering.
  always_comb begin
    idx    = 2'd0;
    is_dot = 1'b0;
    case (state_q)
      DOT0: begin idx = 2'd0; is_dot = 1'b1; end
      DOT1: begin idx = 2'd1; is_dot = 1'b1; end
      DOT2: begin idx = 2'd2; is_dot = 1'b1; end
      SC0:  idx = 2'd0;
      SC1:  idx = 2'd1;
      SC2:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    mul_a = n_q[idx];
    mul_b = is_dot ? {{(ACC_WIDTH-FIXED_WIDTH){d_q[idx][FIXED_WIDTH-1]}}, d_q[idx]} : k_q;
  end

  fixed_mul_shift u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  always_comb begin
    // The accumulator keeps only its own width of each partial product.
    acc_sum = acc_q + prod[ACC_WIDTH-1:0];
    diff    = {{(DIFF_WIDTH-FIXED_WIDTH){d_q[idx][FIXED_WIDTH-1]}}, d_q[idx]}
            - {prod[PROD_WIDTH-1], prod};
    if (SATURATE != 0)
      r_i = sat_fixed({{(WIDE_WIDTH-DIFF_WIDTH){diff[DIFF_WIDTH-1]}}, diff});
    else
      r_i = diff[FIXED_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    n_d        = n_q;
    acc_d      = acc_q;
    k_d        = k_q;
    dot_pend_d = dot_pend_q;
    r_pend_d   = r_pend_q;
    r_d        = r_q;
    dot_d      = dot_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          d_d     = d;
          n_d     = n;
          acc_d   = '0;
          k_d     = '0;
          state_d = DOT0;
        end
      end
      DOT0: begin acc_d = acc_sum; state_d = DOT1; end
      DOT1: begin acc_d = acc_sum; state_d = DOT2; end
      DOT2: begin
        acc_d      = acc_sum;
        k_d        = acc_sum <<< 1;
        dot_pend_d = sat_fixed({{(WIDE_WIDTH-ACC_WIDTH){acc_sum[ACC_WIDTH-1]}}, acc_sum});
        state_d    = SC0;
      end
      SC0: begin r_pend_d[0] = r_i; state_d = SC1; end
      SC1: begin r_pend_d[1] = r_i; state_d = SC2; end
      SC2: begin
        // Outputs change together so r and dot stay coherent between pulses.
        r_d     = {r_i, r_pend_q[1], r_pend_q[0]};
        dot_d   = dot_pend_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      d_q        <= '0;
      n_q        <= '0;
      acc_q      <= '0;
      k_q        <= '0;
      dot_pend_q <= '0;
      r_pend_q   <= '0;
      r_q        <= '0;
      dot_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      n_q        <= n_d;
      acc_q      <= acc_d;
      k_q        <= k_d;
      dot_pend_q <= dot_pend_d;
      r_pend_q   <= r_pend_d;
      r_q        <= r_d;
      dot_q      <= dot_d;
      valid_q    <= valid_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign valid = valid_q;
  assign r     = r_q;
  assign dot   = dot_q;

endmodule

// File: tb/tb_fixed3_reflect.sv
module tb_fixed3_reflect;
  import fixed3_reflect_pkg::*;

  logic  clk = 1'b0;
  logic  reset, strobe;
  Fixed3 d, n;
  logic  busy, valid, busy_w, valid_w;
  Fixed3 r, r_w;
  Fixed  dot, dot_w;

  fixed3_reflect #(.SATURATE(1)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .d(d), .n(n),
    .busy(busy), .valid(valid), .r(r), .dot(dot)
  );

  fixed3_reflect #(.SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .strobe(strobe), .d(d), .n(n),
    .busy(busy_w), .valid(valid_w), .r(r_w), .dot(dot_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    Fixed3 rs;
    Fixed3 rw;
    Fixed  dot;
    int    due;
  } exp_t;

  exp_t sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic Fixed sat64(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  // Reference: r = d - 2(d.n)n in Q16.16 with floor shifts.
  function automatic exp_t model(input Fixed3 dv, input Fixed3 nv, input int due);
    exp_t   e;
    longint acc, k, t;
    acc = 0;
    for (int i = 0; i < 3; i++)
      acc += (longint'(dv[i]) * longint'(nv[i])) >>> 16;
    e.dot = sat64(acc);
    k = acc * 2;
    for (int i = 0; i < 3; i++) begin
      t = longint'(dv[i]) - ((k * longint'(nv[i])) >>> 16);
      e.rs[i] = sat64(t);
      e.rw[i] = t[31:0];
    end
    e.due = due;
    return e;
  endfunction

  function automatic Fixed3 rand_vec(input int unsigned span);
    Fixed3 v;
    for (int i = 0; i < 3; i++)
      v[i] = int'($urandom_range(0, 2 * span)) - int'(span);
    return v;
  endfunction

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    strobe = 1'b1;
    d = rand_vec(1 << 20);
    n = rand_vec(1 << 16);
    tick();
    tick();
    checks++;
    if ({busy, valid, r, dot} !== '0)
      $display("FAIL reset_state got busy=%b valid=%b r=%h dot=%h required all zero", busy, valid, r, dot);
    else passes++;
    checks++;
    if ({busy_w, valid_w, r_w, dot_w} !== '0)
      $display("FAIL reset_state_wrap got busy=%b valid=%b r=%h dot=%h required all zero", busy_w, valid_w, r_w, dot_w);
    else passes++;
    reset  = 1'b0;
    strobe = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle got busy=%b required 0", busy);
    else passes++;
    e = model('0, '0, 0);
  endtask

  task automatic test_back_to_back();
    Fixed3 dv[9], nv[9];
    exp_t  ev[9];
    exp_t  e, last;
    dv[0] = '0; dv[0][0] = 32'h0001_0000; dv[0][1] = 32'hFFFF_0000;
    nv[0] = '0; nv[0][1] = 32'h0001_0000;
    ev[0].rs = '0; ev[0].rs[0] = 32'h0001_0000; ev[0].rs[1] = 32'h0001_0000;
    ev[0].rw = ev[0].rs; ev[0].dot = 32'hFFFF_0000;
    dv[1] = '0; dv[1][2] = 32'hFFFF_0000;
    nv[1] = '0; nv[1][2] = 32'h0001_0000;
    ev[1].rs = '0; ev[1].rs[2] = 32'h0001_0000;
    ev[1].rw = ev[1].rs; ev[1].dot = 32'hFFFF_0000;
    dv[2] = '0; dv[2][0] = 32'h4000_0000;
    nv[2] = '0; nv[2][0] = 32'h0002_0000;
    ev[2].rs = '0; ev[2].rs[0] = 32'h8000_0000;
    ev[2].rw = '0; ev[2].rw[0] = 32'h4000_0000; ev[2].dot = 32'h7FFF_FFFF;
    for (int i = 3; i < 9; i++) begin
      dv[i] = rand_vec(1 << 20);
      nv[i] = rand_vec(1 << 17);
      ev[i] = model(dv[i], nv[i], 0);
    end
    last = ev[0];
    for (int k = 0; k < 9; k++) begin
      d = dv[k];
      n = nv[k];
      strobe = 1'b1;
      e = ev[k];
      e.due = cyc + 7;
      sb.push_back(e);
      tick();
      strobe = 1'b0;
      for (int c = 1; c <= 6; c++) begin
        checks++;
        if ({busy, valid} !== 2'b10)
          $display("FAIL in_flight vec=%0d offset=%0d got busy=%b valid=%b required busy=1 valid=0", k, c, busy, valid);
        else passes++;
        tick();
      end
      checks++;
      if (valid !== 1'b1 || busy !== 1'b0) begin
        $display("FAIL result_cycle vec=%0d got busy=%b valid=%b required busy=0 valid=1", k, busy, valid);
        if (sb.size() != 0) void'(sb.pop_front());
      end else begin
        passes++;
        e = sb.pop_front();
        last = e;
        checks++;
        if (cyc !== e.due) $display("FAIL latency vec=%0d got cycle %0d required %0d", k, cyc, e.due);
        else passes++;
        checks++;
        if ({r, dot} !== {e.rs, e.dot})
          $display("FAIL result_sat vec=%0d got r=%h dot=%h required r=%h dot=%h", k, r, dot, e.rs, e.dot);
        else passes++;
        checks++;
        if ({valid_w, r_w, dot_w} !== {1'b1, e.rw, e.dot})
          $display("FAIL result_wrap vec=%0d got valid=%b r=%h dot=%h required valid=1 r=%h dot=%h",
                   k, valid_w, r_w, dot_w, e.rw, e.dot);
        else passes++;
      end
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({valid, r, dot} !== {1'b0, last.rs, last.dot})
        $display("FAIL hold offset=%0d got valid=%b r=%h dot=%h required valid=0 r=%h dot=%h",
                 c, valid, r, dot, last.rs, last.dot);
      else passes++;
    end
  endtask

  task automatic test_ignore_strobe();
    Fixed3 da, na, db, nb;
    exp_t  e;
    int    t0;
    da = rand_vec(1 << 20); na = rand_vec(1 << 17);
    db = rand_vec(1 << 20); nb = rand_vec(1 << 17);
    t0 = cyc;
    d = da; n = na; strobe = 1'b1;
    sb.push_back(model(da, na, t0 + 7));
    for (int c = 1; c <= 18; c++) begin
      tick();
      strobe = 1'b0;
      if (c == 3) begin
        checks++;
        if (busy !== 1'b1) $display("FAIL busy_mid got busy=%b required 1", busy);
        else passes++;
        d = db; n = nb; strobe = 1'b1;
      end
      if (c == 4) begin d = '1; n = '1; end
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid cycle=%0d got valid=1 required valid=0", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc !== e.due) $display("FAIL ignore_latency got cycle %0d required %0d", cyc, e.due);
          else passes++;
          checks++;
          if ({r, dot} !== {e.rs, e.dot})
            $display("FAIL ignore_result got r=%h dot=%h required r=%h dot=%h", r, dot, e.rs, e.dot);
          else passes++;
          checks++;
          if ({r_w, dot_w} !== {e.rw, e.dot})
            $display("FAIL ignore_result_wrap got r=%h dot=%h required r=%h dot=%h", r_w, dot_w, e.rw, e.dot);
          else passes++;
        end
      end
      if (c == 7) begin
        d = db; n = nb; strobe = 1'b1;
        sb.push_back(model(db, nb, t0 + 14));
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL ignore_missing got %0d pending results required 0", sb.size());
    else passes++;
  endtask

  task automatic test_reset_abort();
    Fixed3 dc, nc;
    exp_t  e;
    int    t0;
    dc = rand_vec(1 << 20); nc = rand_vec(1 << 17);
    t0 = cyc;
    d = rand_vec(1 << 20); n = rand_vec(1 << 17); strobe = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      strobe = 1'b0;
      reset  = 1'b0;
      if (c == 4) reset = 1'b1;
      if (c == 5) begin
        checks++;
        if ({busy, r, dot, busy_w, r_w, dot_w} !== '0)
          $display("FAIL abort_state got busy=%b r=%h dot=%h busy_w=%b required zeros", busy, r, dot, busy_w);
        else passes++;
      end
      if (valid) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_valid cycle=%0d got valid=1 required valid=0", cyc);
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc !== e.due) $display("FAIL abort_latency got cycle %0d required %0d", cyc, e.due);
          else passes++;
          checks++;
          if ({r, dot} !== {e.rs, e.dot})
            $display("FAIL abort_result got r=%h dot=%h required r=%h dot=%h", r, dot, e.rs, e.dot);
          else passes++;
          checks++;
          if ({r_w, dot_w} !== {e.rw, e.dot})
            $display("FAIL abort_result_wrap got r=%h dot=%h required r=%h dot=%h", r_w, dot_w, e.rw, e.dot);
          else passes++;
        end
      end
      if (c == 6) begin
        d = dc; n = nc; strobe = 1'b1;
        sb.push_back(model(dc, nc, t0 + 13));
      end
    end
    checks++;
    if (sb.size() != 0) $display("FAIL abort_missing got %0d pending results required 0", sb.size());
    else passes++;
  endtask

  initial begin
    reset  = 1'b1;
    strobe = 1'b0;
    d = '0;
    n = '0;
    test_reset();
    test_back_to_back();
    test_ignore_strobe();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fixed3_reflect.md
FIXED3_REFLECT -- requirements
Module: fixed3_reflect

Interface
REQ-001 SHALL have parameter SATURATE, default 1: 1 = clamp results to Fixed range, 0 = wrap (two's-complement truncation).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port strobe  input  1  start request; sampled only when busy=0.
REQ-005 SHALL have port d  input  Fixed3  incident direction, signed Q16.16 per component.
REQ-006 SHALL have port n  input  Fixed3  surface normal, signed Q16.16, unit length; driven by the vector-normalise stage's ov output.
REQ-007 SHALL have port busy  output  1  high while a reflection is in progress.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking r and dot as new.
REQ-009 SHALL have port r  output  Fixed3  reflected direction r = d - 2(d·n)n.
REQ-010 SHALL have port dot  output  Fixed  d·n, saturated to Fixed range.

Function
REQ-011 SHALL use one shared signed FIXED_WIDTH x (FIXED_WIDTH+3) multiplier, time-multiplexed, with no other multiply.
REQ-012 SHALL implement states IDLE, DOT0, DOT1, DOT2, SC0, SC1, SC2, in that order, then back to IDLE.
REQ-013 SHALL, in IDLE with strobe=1, latch d and n, clear the accumulator, and move to DOT0; busy = (state != IDLE).
REQ-014 SHALL ignore strobe while busy=1, with no queuing and no effect on latched operands.
REQ-015 SHALL, in DOTi, add (d_i*n_i)>>>FRAC_BITS (arithmetic shift, floor) into a FIXED_WIDTH+3 bit signed accumulator.
REQ-016 SHALL, leaving DOT2, form k = accumulator<<1 at full FIXED_WIDTH+3 width (unsaturated), and register dot = accumulator saturated to [0x80000000, 0x7FFFFFFF].
REQ-017 SHALL, in SCi, compute r_i = d_i - ((k*n_i)>>>FRAC_BITS), then clamp to Fixed range when SATURATE=1, or keep the low FIXED_WIDTH bits when SATURATE=0.
REQ-018 SHALL, on the edge leaving SC2, update r and dot outputs and assert valid for exactly one cycle, with state = IDLE in that same cycle.
REQ-019 SHALL give fixed latency: strobe accepted in cycle T gives valid=1 in cycle T+7; a strobe in cycle T+7 is accepted (throughput one result per 7 cycles).
REQ-020 SHALL hold r and dot stable between valid pulses.
REQ-021 SHALL treat n as given and SHALL NOT renormalise it; a non-unit n yields the formula result, saturated per REQ-017.

Reset
REQ-022 SHALL, on reset=1 at a clock edge, set state=IDLE, busy=0, valid=0, r=(0,0,0), dot=0, and clear the accumulator and k.
REQ-023 SHALL let reset during any non-IDLE state abort the operation, with no valid pulse for the aborted operation.
REQ-024 SHALL give reset priority over a simultaneous strobe.

Structure
REQ-025 SHALL take Fixed, Fixed3, FIXED_WIDTH, FRAC_BITS (16), and FIXED_ONE from the shared fixed-point package; state enum local.
REQ-026 SHALL place the Fixed saturation function (wide signed -> Fixed) in the shared package for reuse by other stages.
REQ-027 SHALL contain one sub-module, fixed_mul_shift: registered-free signed multiply plus >>>FRAC_BITS.

Verification
REQ-028 SHALL pass: d=(0x00010000,0xFFFF0000,0), n=(0,0x00010000,0), strobe at T -> valid at T+7, dot=0xFFFF0000, r=(0x00010000,0x00010000,0).
REQ-029 SHALL pass: d=(0,0,0xFFFF0000), n=(0,0,0x00010000) -> dot=0xFFFF0000, r=(0,0,0x00010000).
REQ-030 SHALL pass, with SATURATE=1: d=(0x40000000,0,0), n=(0x00020000,0,0) -> dot=0x7FFFFFFF, r.x=0x80000000, r.y=r.z=0.
REQ-031 SHALL pass: second strobe at T+3 with different operands -> ignored, single valid at T+7 with first-operand result; strobe at T+7 -> next valid at T+14.
REQ-032 SHALL pass: reset asserted at T+4 -> busy=0, r=0, dot=0 at T+5, no valid at T+7; new strobe at T+6 -> valid at T+13.
